// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
//
// Exception / interrupt sequencer in front of the CP0 register file.
// Owns the single CP0 write port and shares it between the CPU mtc0 path
// and the exception engine. On an exception, interrupt or eret it stalls the
// pipeline, writes EPC, Cause and Status in a fixed order, then pulses a PC
// redirect. Shadow copies of Status, EPC and Cause are kept locally, so the
// CP0 read port is never used.
//
// Optional feature (macro CP0_BADVADDR_EN):
//   Adds input exc_badvaddr and parameter BADV_ADDR. For AdEL/AdES (ExcCode
//   4/5) an extra SAVE_BADV state writes the faulting address between the
//   Cause and Status writes.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   irq[5:0]         level-sensitive interrupt lines -> Status/Cause bit 10+i
//   exc_req          synchronous exception request from the pipeline
//   exc_code[4:0]    ExcCode belonging to exc_req
//   exc_pc[31:0]     PC of the faulting / interrupted instruction
//   eret             eret instruction in execute
//   cpu_we           mtc0 write request
//   cpu_waddr[4:0]   mtc0 target register
//   cpu_wdata[31:0]  mtc0 data
//   exc_badvaddr     (CP0_BADVADDR_EN only) faulting data/instr address
//   stall            freezes the pipeline
//   redirect         one-cycle PC-load pulse
//   redirect_pc      new PC, valid while redirect = 1
//   cp0_we           CP0 write enable
//   cp0_waddr        CP0 write address
//   cp0_wdata        CP0 write data
// -----------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0180,
  parameter logic [4:0]  STATUS_ADDR = 5'd12,
  parameter logic [4:0]  CAUSE_ADDR  = 5'd13,
  parameter logic [4:0]  EPC_ADDR    = 5'd14
`ifdef CP0_BADVADDR_EN
  ,
  parameter logic [4:0]  BADV_ADDR   = 5'd8
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  irq,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        eret,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_waddr,
  input  logic [31:0] cpu_wdata,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] exc_badvaddr,
`endif
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        cp0_we,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SAVE_EPC    = 3'd1,
    S_SAVE_CAUSE  = 3'd2,
    S_SAVE_STATUS = 3'd3,
    S_ERET_STATUS = 3'd4,
    S_REDIRECT    = 3'd5
`ifdef CP0_BADVADDR_EN
    ,
    S_SAVE_BADV   = 3'd6
`endif
  } state_e;

  localparam logic [31:0] EXL_MASK = 32'h0000_0002;

  state_e      state_q, state_d;

  // Shadow registers
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q,    epc_d;
  logic [31:0] cause_q,  cause_d;
  // Set when the running sequence was started by eret (redirect to EPC).
  logic        ret_q,    ret_d;

`ifdef CP0_BADVADDR_EN
  logic [31:0] badv_q,      badv_d;
  logic        need_badv_q, need_badv_d;
`endif

  // ---------------------------------------------------------------------------
  // Event decode in IDLE, in strict priority order:
  //   exception > pending interrupt > eret > mtc0
  // ---------------------------------------------------------------------------
  logic       in_idle;
  logic       irq_pending;
  logic       take_exc;
  logic       take_irq;
  logic       take_trap;
  logic       take_eret;
  logic       take_mtc0;
  logic [4:0] trap_code;

  assign in_idle     = (state_q == S_IDLE);
  // IE set, EXL clear, and at least one unmasked line asserted.
  assign irq_pending = status_q[0] & ~status_q[1] & (|(irq & status_q[15:10]));

  assign take_exc  = in_idle & exc_req;
  assign take_irq  = in_idle & ~exc_req & irq_pending;
  assign take_trap = take_exc | take_irq;
  assign take_eret = in_idle & ~exc_req & ~irq_pending & eret;
  // A cpu_we coinciding with any accepted event is dropped: the redirect that
  // follows flushes the instruction that issued it.
  assign take_mtc0 = in_idle & ~take_trap & ~eret & cpu_we;

  assign trap_code = take_exc ? exc_code : 5'd0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (take_trap) begin
          state_d = S_SAVE_EPC;
        end else if (take_eret) begin
          state_d = S_ERET_STATUS;
        end
      end
      S_SAVE_EPC:    state_d = S_SAVE_CAUSE;
`ifdef CP0_BADVADDR_EN
      S_SAVE_CAUSE:  state_d = need_badv_q ? S_SAVE_BADV : S_SAVE_STATUS;
      S_SAVE_BADV:   state_d = S_SAVE_STATUS;
`else
      S_SAVE_CAUSE:  state_d = S_SAVE_STATUS;
`endif
      S_SAVE_STATUS: state_d = S_REDIRECT;
      S_ERET_STATUS: state_d = S_REDIRECT;
      S_REDIRECT:    state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shadow register next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    status_d = status_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    ret_d    = ret_q;
`ifdef CP0_BADVADDR_EN
    badv_d      = badv_q;
    need_badv_d = need_badv_q;
`endif

    if (take_trap) begin
      // Everything the sequence writes is captured now; inputs are ignored
      // until the sequence returns to IDLE.
      epc_d   = exc_pc;
      cause_d = {16'b0, irq, 3'b0, trap_code, 2'b0};
      ret_d   = 1'b0;
`ifdef CP0_BADVADDR_EN
      badv_d      = exc_badvaddr;
      need_badv_d = take_exc & ((exc_code == 5'd4) | (exc_code == 5'd5));
`endif
    end else if (take_eret) begin
      ret_d = 1'b1;
    end else if (take_mtc0) begin
      // Only Status and EPC are mirrored; other targets (including register
      // 0) are forwarded to CP0 without touching the shadows.
      if (cpu_waddr == STATUS_ADDR) begin
        status_d = cpu_wdata;
      end
      if (cpu_waddr == EPC_ADDR) begin
        epc_d = cpu_wdata;
      end
    end

    // EXL follows the Status value written to CP0 in the same cycle.
    if (state_q == S_SAVE_STATUS) begin
      status_d = status_q | EXL_MASK;
    end else if (state_q == S_ERET_STATUS) begin
      status_d = status_q & ~EXL_MASK;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Sequence writes are Moore outputs of the state register;
  // in IDLE the mtc0 path and the first stall cycle are combinational.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    cp0_we      = 1'b0;
    cp0_waddr   = 5'd0;
    cp0_wdata   = 32'h0;

    unique case (state_q)
      S_IDLE: begin
        stall = take_trap | take_eret;
        if (take_mtc0) begin
          cp0_we    = 1'b1;
          cp0_waddr = cpu_waddr;
          cp0_wdata = cpu_wdata;
        end
      end
      S_SAVE_EPC: begin
        stall     = 1'b1;
        cp0_we    = 1'b1;
        cp0_waddr = EPC_ADDR;
        cp0_wdata = epc_q;
      end
      S_SAVE_CAUSE: begin
        stall     = 1'b1;
        cp0_we    = 1'b1;
        cp0_waddr = CAUSE_ADDR;
        cp0_wdata = cause_q;
      end
`ifdef CP0_BADVADDR_EN
      S_SAVE_BADV: begin
        stall     = 1'b1;
        cp0_we    = 1'b1;
        cp0_waddr = BADV_ADDR;
        cp0_wdata = badv_q;
      end
`endif
      S_SAVE_STATUS: begin
        stall     = 1'b1;
        cp0_we    = 1'b1;
        cp0_waddr = STATUS_ADDR;
        cp0_wdata = status_q | EXL_MASK;
      end
      S_ERET_STATUS: begin
        stall     = 1'b1;
        cp0_we    = 1'b1;
        cp0_waddr = STATUS_ADDR;
        cp0_wdata = status_q & ~EXL_MASK;
      end
      S_REDIRECT: begin
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = ret_q ? epc_q : EXC_VECTOR;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the shadows are a handful of flops, not a memory array, and must
  // come out of reset at zero so IE=0 masks interrupts until software sets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 32'h0;
      epc_q    <= 32'h0;
      cause_q  <= 32'h0;
      ret_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      ret_q    <= ret_d;
    end
  end

`ifdef CP0_BADVADDR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      badv_q      <= 32'h0;
      need_badv_q <= 1'b0;
    end else begin
      badv_q      <= badv_d;
      need_badv_q <= need_badv_d;
    end
  end
`endif

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Exception/interrupt sequencer for the CP0 register file of the MIPS core. It arbitrates the single CP0 write port between the CPU's `mtc0` path and the exception engine. On an exception, interrupt or `eret` it stalls the pipeline and writes EPC, Cause and Status in a fixed order, then redirects the PC. It keeps shadow copies of Status and EPC, so it never needs the CP0 read port.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h0000_0180: exception handler entry PC.
- `STATUS_ADDR`, 5'd12: CP0 Status register index.
- `CAUSE_ADDR`, 5'd13: CP0 Cause register index.
- `EPC_ADDR`, 5'd14: CP0 EPC register index.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq`  in  6  hardware interrupt lines, level-sensitive; bit i maps to Status/Cause bit 10+i.
- `exc_req`  in  1  synchronous exception request from the pipeline.
- `exc_code`  in  5  ExcCode for `exc_req`.
- `exc_pc`  in  32  PC of the faulting or interrupted instruction.
- `eret`  in  1  `eret` instruction in execute.
- `cpu_we`  in  1  `mtc0` write request.
- `cpu_waddr`  in  5  `mtc0` target register.
- `cpu_wdata`  in  32  `mtc0` data.
- `stall`  out  1  freezes the pipeline.
- `redirect`  out  1  one-cycle PC-load pulse.
- `redirect_pc`  out  32  new PC; valid while `redirect`=1.
- `cp0_we`  out  1  CP0 write enable.
- `cp0_waddr`  out  5  CP0 write address.
- `cp0_wdata`  out  32  CP0 write data.

## Operation
- Shadow registers:
  - `status_q`: IE is bit 0, EXL is bit 1, IM is bits 15:10.
  - `epc_q`.
  - `cause_q`: latched ExcCode plus IP snapshot.
- Interrupt pending when `status_q[0]`=1, `status_q[1]`=0 and `(irq & status_q[15:10]) != 0`.
- In IDLE, priority is `exc_req` > pending interrupt > `eret` > `cpu_we`.
- Accepting an exception or interrupt latches three values:
  - `exc_pc` into `epc_q`.
  - Cause = {16'b0, irq, 3'b0, code, 2'b0}.
  - code = `exc_code` for an exception, 5'd0 for an interrupt.
- FSM states: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, ERET_STATUS, REDIRECT (plus SAVE_BADV under the macro).
  - IDLE→SAVE_EPC on an exception or interrupt; IDLE→ERET_STATUS on `eret`.
  - SAVE_EPC→SAVE_CAUSE→SAVE_STATUS→REDIRECT.
  - ERET_STATUS→REDIRECT.
  - REDIRECT→IDLE.
- Writes per state:
  - SAVE_EPC writes `epc_q` to EPC_ADDR.
  - SAVE_CAUSE writes the Cause value to CAUSE_ADDR.
  - SAVE_STATUS writes `status_q | 2` to STATUS_ADDR and sets shadow EXL.
  - ERET_STATUS writes `status_q & ~2` and clears shadow EXL.
- REDIRECT: `redirect`=1; `redirect_pc` = EXC_VECTOR after an exception or interrupt, `epc_q` after `eret`.
- `mtc0` path, active in IDLE only when no higher-priority event is present:
  - `cp0_we`/`cp0_waddr`/`cp0_wdata` follow `cpu_*` combinationally.
  - A write to STATUS_ADDR or EPC_ADDR also updates the shadow on the same edge.
  - A write to address 0 is forwarded but does not touch the shadows.
- A `cpu_we` arriving in the same cycle as an accepted event is dropped; the pipeline is flushed by the redirect.
- A synchronous exception while EXL=1 is still taken and overwrites EPC and Cause.
- Inputs are ignored outside IDLE; `irq` is level-sensitive, so a still-asserted line is re-evaluated on return to IDLE.

## Timing
- Reset values: state IDLE; all shadows 0; `stall`, `redirect`, `cp0_we` = 0; `redirect_pc`, `cp0_waddr`, `cp0_wdata` = 0.
- Exception or interrupt accepted in IDLE at cycle N:
  - CP0 writes at N+1 (EPC), N+2 (Cause), N+3 (Status).
  - `redirect` at N+4.
  - `stall`=1 combinationally from N through N+4 inclusive.
- `eret` at N: Status write at N+1, `redirect` at N+2, `stall` from N through N+2.
- `mtc0`: zero latency, no stall.
- State-machine write outputs are Moore outputs, registered from the state.
- `rst_n` low mid-sequence: immediate return to IDLE with all outputs 0; partially written CP0 contents are not restored.

## Configuration
- `CP0_BADVADDR_EN` defined:
  - Adds input `exc_badvaddr` (32 bits) and parameter `BADV_ADDR` (default 5'd8).
  - When `exc_code` is 4 or 5 (AdEL/AdES), SAVE_BADV is inserted between SAVE_CAUSE and SAVE_STATUS and writes `exc_badvaddr`.
  - Redirect latency for those codes becomes N+5.
- Undefined: no port, no state; all exceptions use the 4-cycle sequence.

## Test plan
- Reset, then `mtc0` Status=32'h0000_0401 → `cp0_we`=1 same cycle with addr 12 and data 32'h401, `stall`=0; shadow IE=1, IM[10]=1.
- `exc_req`, code 5'd12, `exc_pc`=32'h0040_0020 → writes: EPC=32'h0040_0020, Cause=32'h0000_0030, Status=32'h0000_0403 → `redirect` with PC 32'h180 at N+4; `stall` high for 5 cycles.
- IE=1, IM[10]=1, `irq[0]`=1, `exc_pc`=32'h0040_0100 → Cause=32'h0000_0400 → redirect to 32'h180; a second `irq` during EXL=1 is not taken.
- `eret` after the previous case → Status write 32'h0000_0401 at N+1, `redirect_pc`=32'h0040_0100 at N+2.
- Same-cycle `exc_req`+`eret`+`cpu_we` → only the exception sequence runs; no `mtc0` write appears; then `rst_n` pulsed low at SAVE_CAUSE → all outputs 0 and IDLE immediately.
- With `CP0_BADVADDR_EN` defined: code 5'd4, `exc_badvaddr`=32'h1000_0003 → write to reg 8 at N+3, Status at N+4, `redirect` at N+5.
